// File: rtl/keypad_pkg.sv
// Shared types for the multi-digit keypad lock: FSM states, registered output
// vector and the state-to-output decode.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY = 3'd0,
        ST_OPEN  = 3'd1,
        ST_RSTS  = 3'd2,
        ST_SECV  = 3'd3,
        ST_LKOUT = 3'd4,
        ST_OFF   = 3'd5
    } kp_state_t;

    typedef struct packed {
        logic lock;
        logic ulck;
        logic rsto;
        logic secv;
        logic lkout;
    } kp_out_t;

    function automatic kp_out_t kp_decode(input kp_state_t s);
        kp_out_t o;
        o = '0;
        case (s)
            ST_ENTRY: o.lock = 1'b1;
            ST_OPEN:  o.ulck = 1'b1;
            ST_RSTS:  begin o.lock = 1'b1; o.rsto  = 1'b1; end
            ST_SECV:  begin o.lock = 1'b1; o.secv  = 1'b1; end
            ST_LKOUT: begin o.lock = 1'b1; o.lkout = 1'b1; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    function automatic int kp_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating up-counter shared by the inter-digit timeout, the open window and
// the lockout period; expired flags the last cycle of the selected limit.
module cycle_timer #(
    parameter int W = 6
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         expired
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = en && (cnt == (limit - W'(1)));

endmodule

// File: rtl/keypad_lock_multi.sv
// N-digit passcode lock with failed-attempt lockout, inter-digit timeout,
// timed unlock window and tamper alarm; all outputs registered.
module keypad_lock_multi
    import keypad_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_FAIL    = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter int OPEN_CYC    = 3,
    parameter int LOCKOUT_CYC = 32
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            ENBL,
    input  logic                            SECI,
    input  logic                            DIG_VLD,
    input  logic [DIGIT_W-1:0]              DIG,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   CODE,
    output logic                            LOCK,
    output logic                            ULCK,
    output logic                            RSTO,
    output logic                            SECV,
    output logic                            LKOUT,
    output logic [$clog2(NUM_DIGITS+1)-1:0] DIG_CNT
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(kp_max3(TIMEOUT_CYC, OPEN_CYC, LOCKOUT_CYC) + 1);

    kp_state_t         state_q, state_d;
    kp_out_t           out_q;
    logic [CW-1:0]     dig_cnt_q;
    logic              mis_q;
    logic [FW-1:0]     fail_q, fail_next;
    logic [DIGIT_W-1:0] code_dig;
    logic              dig_ok, last_dig;
    logic              accept, fail_inc, fail_clr;
    logic              tmr_load, tmr_en, tmr_exp;
    logic [TW-1:0]     tmr_limit, tmr_cnt;

    // Digit handshake: DIG is taken on any cycle DIG_VLD is high while the FSM
    // sits in ENTRY; there is no ready, strobes in any other state are dropped.
    always_comb begin
        code_dig = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_cnt_q == CW'(i)) code_dig = CODE[i*DIGIT_W +: DIGIT_W];
        end
    end

    assign dig_ok    = (DIG == code_dig);
    assign last_dig  = (dig_cnt_q == CW'(NUM_DIGITS - 1));
    assign fail_next = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        fail_inc = 1'b0;
        fail_clr = 1'b0;
        if (!ENBL) begin
            state_d = ST_OFF;
        end else if (SECI) begin
            state_d = ST_SECV;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (DIG_VLD) begin
                        accept = 1'b1;
                        if (last_dig) begin
                            // Verdict only on the final digit; no early hint of a wrong one.
                            if (!mis_q && dig_ok) begin
                                state_d  = ST_OPEN;
                                fail_clr = 1'b1;
                            end else begin
                                fail_inc = 1'b1;
                                state_d  = (fail_next == FW'(MAX_FAIL)) ? ST_LKOUT : ST_RSTS;
                            end
                        end
                    end else if ((dig_cnt_q != '0) && tmr_exp) begin
                        state_d = ST_RSTS;
                    end
                end
                ST_OPEN:  if (tmr_exp) state_d = ST_RSTS;
                // A lockout interrupted by tamper or power-off restarts in full.
                ST_RSTS:  state_d = (fail_q == FW'(MAX_FAIL)) ? ST_LKOUT : ST_ENTRY;
                ST_SECV:  state_d = ST_RSTS;
                ST_LKOUT: begin
                    if (tmr_exp) begin
                        state_d  = ST_RSTS;
                        fail_clr = 1'b1;
                    end
                end
                ST_OFF:   state_d = ST_RSTS;
                default:  state_d = ST_ENTRY;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            ST_OPEN:  tmr_limit = TW'(OPEN_CYC);
            ST_LKOUT: tmr_limit = TW'(LOCKOUT_CYC);
            default:  tmr_limit = TW'(TIMEOUT_CYC);
        endcase
    end

    assign tmr_en   = ((state_q == ST_ENTRY) && (dig_cnt_q != '0)) ||
                      (state_q == ST_OPEN) || (state_q == ST_LKOUT);
    assign tmr_load = (state_d != state_q) || accept ||
                      ((state_q == ST_ENTRY) && (dig_cnt_q == '0));

    cycle_timer #(.W(TW)) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .load    (tmr_load),
        .en      (tmr_en),
        .limit   (tmr_limit),
        .cnt     (tmr_cnt),
        .expired (tmr_exp)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_ENTRY;
            out_q     <= kp_decode(ST_ENTRY);
            dig_cnt_q <= '0;
            mis_q     <= 1'b0;
            fail_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= kp_decode(state_d);
            if (accept && (state_d == ST_ENTRY)) begin
                dig_cnt_q <= dig_cnt_q + CW'(1);
                mis_q     <= mis_q | ~dig_ok;
            end else if ((state_d != ST_ENTRY) || (state_q != ST_ENTRY)) begin
                dig_cnt_q <= '0;
                mis_q     <= 1'b0;
            end
            if (fail_clr) begin
                fail_q <= '0;
            end else if (fail_inc) begin
                fail_q <= fail_next;
            end
        end
    end

    assign LOCK    = out_q.lock;
    assign ULCK    = out_q.ulck;
    assign RSTO    = out_q.rsto;
    assign SECV    = out_q.secv;
    assign LKOUT   = out_q.lkout;
    assign DIG_CNT = dig_cnt_q;

endmodule

// File: tb/tb_keypad_lock_multi.sv
// Directed bench for keypad_lock_multi (CODE 16'h4321): per-cycle expected output
// vectors are queued by the driver and compared by a negedge monitor.
module tb_keypad_lock_multi;

    logic        CLK;
    logic        RST;
    logic        ENBL;
    logic        SECI;
    logic        DIG_VLD;
    logic [3:0]  DIG;
    logic [15:0] CODE;
    logic        LOCK, ULCK, RSTO, SECV, LKOUT;
    logic [2:0]  DIG_CNT;

    keypad_lock_multi #(
        .NUM_DIGITS(4), .DIGIT_W(4), .MAX_FAIL(3),
        .TIMEOUT_CYC(16), .OPEN_CYC(3), .LOCKOUT_CYC(32)
    ) dut (
        .CLK(CLK), .RST(RST), .ENBL(ENBL), .SECI(SECI),
        .DIG_VLD(DIG_VLD), .DIG(DIG), .CODE(CODE),
        .LOCK(LOCK), .ULCK(ULCK), .RSTO(RSTO), .SECV(SECV),
        .LKOUT(LKOUT), .DIG_CNT(DIG_CNT)
    );

    // Expected vector layout: {LOCK, ULCK, RSTO, SECV, LKOUT, DIG_CNT[2:0]}
    localparam logic [7:0] E_OPEN  = 8'b01000_000;
    localparam logic [7:0] E_RSTS  = 8'b10100_000;
    localparam logic [7:0] E_SECV  = 8'b10010_000;
    localparam logic [7:0] E_LKOUT = 8'b10001_000;
    localparam logic [7:0] E_OFF   = 8'b00000_000;

    function automatic logic [7:0] e_entry(input logic [2:0] dc);
        return {5'b10000, dc};
    endfunction

    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         errors = 0;

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // monitor / scoreboard
    always @(negedge CLK) begin
        logic [7:0] act, e;
        string      t;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {LOCK, ULCK, RSTO, SECV, LKOUT, DIG_CNT};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got {L,U,R,S,K,cnt}=%b required %b at %0t", t, act, e, $time);
            end
        end
    end

    // driver tasks
    task automatic step(input logic rst, input logic enbl, input logic seci,
                        input logic vld, input logic [3:0] dig,
                        input logic [7:0] e, input string tag);
        RST = rst; ENBL = enbl; SECI = seci; DIG_VLD = vld; DIG = dig;
        @(posedge CLK);
        #1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic key(input logic [3:0] d, input logic [7:0] e, input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b1, d, e, tag);
    endtask

    task automatic idle(input int n, input logic [7:0] e, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, e, tag);
    endtask

    task automatic enter4(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3,
                          input logic [7:0] last_e, input string tag);
        key(d0, e_entry(3'd1), tag);
        key(d1, e_entry(3'd2), tag);
        key(d2, e_entry(3'd3), tag);
        key(d3, last_e, tag);
    endtask

    initial begin
        RST = 1'b1; ENBL = 1'b1; SECI = 1'b0; DIG_VLD = 1'b0; DIG = '0;
        CODE = 16'h4321;

        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, e_entry(3'd0), "reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, e_entry(3'd0), "reset");

        // 1: correct code
        enter4(4'h1, 4'h2, 4'h3, 4'h4, E_OPEN, "t1_entry");
        idle(2, E_OPEN, "t1_open");
        idle(1, E_RSTS, "t1_rsto");
        idle(1, e_entry(3'd0), "t1_back");

        // 2: wrong second digit, silent until the fourth (fail 1)
        enter4(4'h1, 4'h9, 4'h3, 4'h4, E_RSTS, "t2_wrong");
        idle(1, e_entry(3'd0), "t2_back");

        // 3: two more failures reach lockout; correct code ignored inside
        enter4(4'h0, 4'h0, 4'h0, 4'h0, E_RSTS, "t3_fail2");
        idle(1, e_entry(3'd0), "t3_back2");
        enter4(4'h4, 4'h3, 4'h2, 4'h1, E_LKOUT, "t3_fail3");
        idle(10, E_LKOUT, "t3_lkout");
        key(4'h1, E_LKOUT, "t3_ign");
        key(4'h2, E_LKOUT, "t3_ign");
        key(4'h3, E_LKOUT, "t3_ign");
        key(4'h4, E_LKOUT, "t3_ign");
        idle(17, E_LKOUT, "t3_lkout");
        idle(1, E_RSTS, "t3_exit");
        idle(1, e_entry(3'd0), "t3_entry");

        // 4: timeout after 16 idle cycles, then digit on the 16th cycle wins
        key(4'h1, e_entry(3'd1), "t4_d1");
        key(4'h2, e_entry(3'd2), "t4_d2");
        idle(15, e_entry(3'd2), "t4_wait");
        idle(1, E_RSTS, "t4_expire");
        idle(1, e_entry(3'd0), "t4_back");
        key(4'h1, e_entry(3'd1), "t4_d1b");
        key(4'h2, e_entry(3'd2), "t4_d2b");
        idle(15, e_entry(3'd2), "t4_waitb");
        key(4'h3, e_entry(3'd3), "t4_race");
        key(4'h4, E_OPEN, "t4_open");
        idle(2, E_OPEN, "t4_open");
        idle(1, E_RSTS, "t4_rsto");
        idle(1, e_entry(3'd0), "t4_entry");

        // 5: tamper mid-entry, then power-off while open
        key(4'h1, e_entry(3'd1), "t5_d1");
        key(4'h2, e_entry(3'd2), "t5_d2");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, (i == 2), 4'h3, E_SECV, "t5_secv");
        idle(1, E_RSTS, "t5_rsto");
        idle(1, e_entry(3'd0), "t5_entry");
        enter4(4'h1, 4'h2, 4'h3, 4'h4, E_OPEN, "t5_open");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, E_OFF, "t5_off");
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'h1, E_OFF, "t5_off_hold");
        idle(1, E_RSTS, "t5_on");
        idle(1, e_entry(3'd0), "t5_on_entry");

        // 6: reset in the middle of lockout clears fail count
        enter4(4'h9, 4'h9, 4'h9, 4'h9, E_RSTS, "t6_f1");
        idle(1, e_entry(3'd0), "t6_b1");
        enter4(4'h9, 4'h9, 4'h9, 4'h9, E_RSTS, "t6_f2");
        idle(1, e_entry(3'd0), "t6_b2");
        enter4(4'h9, 4'h9, 4'h9, 4'h9, E_LKOUT, "t6_f3");
        idle(5, E_LKOUT, "t6_lkout");
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, e_entry(3'd0), "t6_rst");
        enter4(4'h9, 4'h9, 4'h9, 4'h9, E_RSTS, "t6_fail_after_rst");
        idle(1, e_entry(3'd0), "t6_b3");
        enter4(4'h1, 4'h2, 4'h3, 4'h4, E_OPEN, "t6_open");
        idle(2, E_OPEN, "t6_open");
        idle(1, E_RSTS, "t6_rsto");
        idle(1, e_entry(3'd0), "t6_entry");

        // 7: tamper during lockout restarts a full lockout afterwards
        enter4(4'h0, 4'h0, 4'h0, 4'h0, E_RSTS, "t7_f1");
        idle(1, e_entry(3'd0), "t7_b1");
        enter4(4'h0, 4'h0, 4'h0, 4'h0, E_RSTS, "t7_f2");
        idle(1, e_entry(3'd0), "t7_b2");
        enter4(4'h0, 4'h0, 4'h0, 4'h0, E_LKOUT, "t7_f3");
        idle(3, E_LKOUT, "t7_lkout");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, E_SECV, "t7_secv");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, E_SECV, "t7_secv");
        idle(1, E_RSTS, "t7_rsto");
        idle(32, E_LKOUT, "t7_relock");
        idle(1, E_RSTS, "t7_exit");
        idle(1, e_entry(3'd0), "t7_entry");

        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
